// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle RISC-V style datapath (lw, sw, R-type,
//   I-type ALU, jal, beq, bne). Each state drives datapath enables and mux
//   selects. Undecodable instructions park the machine in TRAP until reset.
//   A counter tracks retired instructions.
//
// Parameters
//   SUPPORT_IALU  1 enables I-type ALU ops (op 0010011)
//   SUPPORT_JAL   1 enables jal (op 1101111)
//   SUPPORT_BNE   1 enables bne (op 1100011, funct3 001)
//   WAIT_MEM      0 treats mem_ready as permanently high
//   CNT_W         width of the retired-instruction counter
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   op, funct3            fields from the instruction register
//   Zero                  ALU zero flag
//   mem_ready             memory access complete
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc             00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA               00 PC, 01 OldPC, 10 RD1
//   ALUSrcB               00 RD2, 01 Imm, 10 constant 4
//   ALUOp                 00 add, 01 sub, 10 funct-decoded
//   ImmSrc                00 I, 01 S, 10 B, 11 J
//   illegal               sticky illegal-instruction flag
//   retired               retired-instruction count (wraps silently)
//   state                 current state code
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter bit SUPPORT_IALU = 1'b1,
  parameter bit SUPPORT_JAL  = 1'b1,
  parameter bit SUPPORT_BNE  = 1'b1,
  parameter bit WAIT_MEM     = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             memReady;
  logic             retireEvent;

  // Without memory wait states every access completes in one cycle.
  assign memReady = WAIT_MEM ? mem_ready : 1'b1;

  // An instruction retires on the edge that leaves its final state.
  assign retireEvent = (state_q == MEMWB) || (state_q == ALUWB) ||
                       (state_q == BRANCH) ||
                       ((state_q == MEMWRITE) && memReady);

  // Next-state selection; op/funct3 come from the instruction register and
  // stay stable for the whole instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (memReady) state_d = DECODE;
      DECODE: begin
        if (op == OP_LOAD || op == OP_STORE)
          state_d = MEMADR;
        else if (op == OP_RTYPE)
          state_d = EXECR;
        else if (op == OP_ITYPE && SUPPORT_IALU)
          state_d = EXECI;
        else if (op == OP_JAL && SUPPORT_JAL)
          state_d = JAL;
        else if (op == OP_BRANCH &&
                 (funct3 == F3_BEQ || (funct3 == F3_BNE && SUPPORT_BNE)))
          state_d = BRANCH;
        else
          state_d = TRAP;
      end
      MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (memReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (memReady) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      BRANCH:   state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // State and retired counter; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retireEvent)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output decode. Write enables are additionally masked by reset so that an
  // asserted reset can never let a write through, even in FETCH with
  // mem_ready high.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = memReady;
        PCWrite   = memReady;
      end
      DECODE: begin
        // OldPC + imm precomputes the branch/jump target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 2'b11 : 2'b10;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_LOAD) ? 2'b00 : 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = (funct3 == F3_BNE) ? ~Zero : Zero;
      end
      default: begin
      end
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // TRAP is only left through reset, so the flag is sticky by construction.
  assign illegal = (state_q == TRAP);
  assign retired = retired_q;
  assign state   = state_q;

endmodule
